// File: rtl/ascon_bridge_pkg.sv
// Shared types and helpers for the ASCON pad bridge.
package ascon_bridge_pkg;

   localparam int WORD_W = 64;

   typedef enum logic {IDLE, SHIFT} ser_state_t;

   function automatic int beats(input int width);
      return WORD_W / width;
   endfunction

endpackage

// File: rtl/ascon_bridge_fifo.sv
// Circular word FIFO with a registered head word, head-valid and not-full flag.
module ascon_bridge_fifo #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WORD_W-1:0]          push_data,
   input  logic                       pop,
   output logic [WORD_W-1:0]          head,
   output logic                       head_valid,
   output logic                       ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_q, wr_q, rd_next;
   logic [CW-1:0]     cnt_q, cnt_next;
   logic [WORD_W-1:0] head_q;
   logic              valid_q, ready_q;
   logic              do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_next = rd_q + PW'(do_pop);

   always_comb begin
      cnt_next = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= push_data;
   end

   // Head register follows the next read slot; a push landing there is forwarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         rd_q    <= rd_next;
         cnt_q   <= cnt_next;
         valid_q <= (cnt_next != '0);
         ready_q <= (cnt_next < CW'(DEPTH));
         head_q  <= (do_push && (wr_q == rd_next)) ? push_data : mem[rd_next];
      end
   end

   assign head       = head_q;
   assign head_valid = valid_q;
   assign ready      = ready_q;
   assign count      = cnt_q;

endmodule

// File: rtl/ascon_pad_bridge.sv
// Pad-side word assembler, FIFO and result serialiser for the ASCON core.
// Optional odd-parity checking on input beats: define ASCON_BRIDGE_PARITY_EN.
module ascon_pad_bridge
   import ascon_bridge_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int OUT_W = 4,
   parameter int DEPTH = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              pad_valid_i,
   input  logic [IN_W-1:0]   pad_data_i,
   input  logic              pad_par_i,
   output logic              pad_ready_o,
   output logic [OUT_W-1:0]  pad_out_o,
   output logic              pad_out_valid_o,
   output logic [OUT_W:0]    pad_oeb_o,
   output logic [WORD_W-1:0] in_word_o,
   output logic              in_valid_o,
   input  logic              in_ready_i,
   input  logic [WORD_W-1:0] res_word_i,
   input  logic              res_valid_i,
   output logic              res_ready_o,
   output logic              ovf_o,
   output logic              err_o
);

   localparam int NI  = beats(IN_W);
   localparam int NO  = beats(OUT_W);
   localparam int ICW = (NI > 1) ? $clog2(NI) : 1;
   localparam int OCW = (NO > 1) ? $clog2(NO) : 1;

   logic [ICW-1:0]    icnt_q;
   logic [WORD_W-1:0] asm_q, asm_next;
   logic              last_in, word_bad, push_req, fifo_full, ovf_q;
   logic [$clog2(DEPTH+1)-1:0] unused_count;
   logic              unused_empty;

   always_comb begin
      asm_next = asm_q;
      asm_next[icnt_q*IN_W +: IN_W] = pad_data_i;
   end

   assign last_in  = pad_valid_i & (icnt_q == ICW'(NI-1));
   assign push_req = last_in & ~word_bad;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         icnt_q <= '0;
         asm_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (pad_valid_i) begin
            asm_q  <= asm_next;
            icnt_q <= last_in ? '0 : icnt_q + ICW'(1);
         end
         if (push_req && fifo_full && !in_ready_i) ovf_q <= 1'b1;
      end
   end

`ifdef ASCON_BRIDGE_PARITY_EN
   logic beat_bad, bad_q, err_q;

   assign beat_bad = pad_valid_i & ~(^{pad_data_i, pad_par_i});
   assign word_bad = bad_q | beat_bad;

   // bad_q remembers a parity miss in earlier beats of the word being built
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         bad_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (beat_bad) err_q <= 1'b1;
         if (pad_valid_i) bad_q <= last_in ? 1'b0 : word_bad;
      end
   end

   assign err_o = err_q;
`else
   logic unused_par;

   assign unused_par = pad_par_i;
   assign word_bad   = 1'b0;
   assign err_o      = 1'b0;
`endif

   ascon_bridge_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .push       (push_req),
      .push_data  (asm_next),
      .pop        (in_ready_i),
      .head       (in_word_o),
      .head_valid (in_valid_o),
      .ready      (pad_ready_o),
      .count      (unused_count),
      .full       (fifo_full),
      .empty      (unused_empty)
   );

   assign ovf_o = ovf_q;

   ser_state_t        state_q;
   logic [OCW-1:0]    ocnt_q;
   logic [WORD_W-1:0] sh_q;
   logic [OUT_W-1:0]  out_q;
   logic              outv_q, last_out, res_hs;

   assign last_out    = (ocnt_q == OCW'(NO-1));
   assign res_ready_o = (state_q == IDLE) | last_out;
   assign res_hs      = res_valid_i & res_ready_o;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         ocnt_q  <= '0;
         sh_q    <= '0;
         out_q   <= '0;
         outv_q  <= 1'b0;
      end else if (res_hs) begin
         state_q <= SHIFT;
         ocnt_q  <= '0;
         out_q   <= res_word_i[OUT_W-1:0];
         sh_q    <= res_word_i >> OUT_W;
         outv_q  <= 1'b1;
      end else if (state_q == SHIFT) begin
         if (!last_out) begin
            ocnt_q <= ocnt_q + OCW'(1);
            out_q  <= sh_q[OUT_W-1:0];
            sh_q   <= sh_q >> OUT_W;
         end else begin
            state_q <= IDLE;
            out_q   <= '0;
            outv_q  <= 1'b0;
         end
      end
   end

   assign pad_out_o       = out_q;
   assign pad_out_valid_o = outv_q;
   assign pad_oeb_o       = '0;

endmodule

// File: tb/tb_ascon_pad_bridge.sv
// Self-checking bench for ascon_pad_bridge with default lane widths and depth.
module tb_ascon_pad_bridge;

   localparam int IN_W  = 32;
   localparam int OUT_W = 4;
   localparam int DEPTH = 4;
   localparam int NB    = 64 / IN_W;
   localparam int NO    = 64 / OUT_W;

   logic             clk = 1'b0;
   logic             rst;
   logic             pad_valid;
   logic [IN_W-1:0]  pad_data;
   logic             pad_par;
   logic             pad_ready;
   logic [OUT_W-1:0] pad_out;
   logic             pad_out_valid;
   logic [OUT_W:0]   pad_oeb;
   logic [63:0]      in_word;
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      res_word;
   logic             res_valid;
   logic             res_ready;
   logic             ovf;
   logic             err;

   always #5 clk = ~clk;

   ascon_pad_bridge #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (rst),
      .pad_valid_i     (pad_valid),
      .pad_data_i      (pad_data),
      .pad_par_i       (pad_par),
      .pad_ready_o     (pad_ready),
      .pad_out_o       (pad_out),
      .pad_out_valid_o (pad_out_valid),
      .pad_oeb_o       (pad_oeb),
      .in_word_o       (in_word),
      .in_valid_o      (in_valid),
      .in_ready_i      (in_ready),
      .res_word_i      (res_word),
      .res_valid_i     (res_valid),
      .res_ready_o     (res_ready),
      .ovf_o           (ovf),
      .err_o           (err)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] q[$];
   logic [63:0] w[5];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [63:0] word, input bit pop_last);
      for (int b = 0; b < NB; b++) begin
         pad_valid = 1'b1;
         pad_data  = word[b*IN_W +: IN_W];
         pad_par   = ~^pad_data;
         if (b == NB-1 && pop_last) in_ready = 1'b1;
         tick();
      end
      pad_valid = 1'b0;
      in_ready  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pad_ready"}, pad_ready, 1);
      check({tag, "_pad_out"}, pad_out, 0);
      check({tag, "_pad_out_valid"}, pad_out_valid, 0);
      check({tag, "_pad_oeb"}, pad_oeb, 0);
      check({tag, "_in_word"}, in_word, 0);
      check({tag, "_in_valid"}, in_valid, 0);
      check({tag, "_res_ready"}, res_ready, 1);
      check({tag, "_ovf"}, ovf, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] a, b, r, x, exp_nib;
      int          sent, bi, cyc;
      logic [63:0] cur;

      rst = 1'b1; pad_valid = 1'b0; pad_data = '0; pad_par = 1'b0;
      in_ready = 1'b0; res_word = '0; res_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_vals("reset");

      // assembly: two beats LSB-first, word visible the cycle after the final beat
      pad_valid = 1'b1; pad_data = 32'h1111_1111; pad_par = ~^pad_data;
      tick();
      check("asm_not_yet", in_valid, 0);
      pad_data = 32'h2222_2222; pad_par = ~^pad_data;
      tick();
      pad_valid = 1'b0;
      check("asm_valid", in_valid, 1);
      check("asm_word", in_word, 64'h2222_2222_1111_1111);
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      check("asm_popped", in_valid, 0);

      // overflow: five words into a four-deep FIFO with no pops
      for (int i = 0; i < 5; i++) w[i] = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
         send_word(w[i], 1'b0);
         if (i == 2) check("ovf_ready_before_full", pad_ready, 1);
      end
      check("ovf_ready_full", pad_ready, 0);
      check("ovf_before", ovf, 0);
      send_word(w[4], 1'b0);
      check("ovf_set", ovf, 1);
      in_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("ovf_pop_valid", in_valid, 1);
         check("ovf_pop_word", in_word, w[i]);
         tick();
      end
      in_ready = 1'b0;
      check("ovf_drained", in_valid, 0);
      check("ovf_ready_again", pad_ready, 1);
      check("ovf_sticky", ovf, 1);

      // full FIFO with a pop on the final beat of the fifth word
      do_reset();
      check("full_pop_ovf_cleared", ovf, 0);
      for (int i = 0; i < 5; i++) w[i] = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) send_word(w[i], 1'b0);
      send_word(w[4], 1'b1);
      check("full_pop_no_ovf", ovf, 0);
      check("full_pop_still_full", pad_ready, 0);
      in_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check("full_pop_valid", in_valid, 1);
         check("full_pop_word", in_word, w[i]);
         tick();
      end
      in_ready = 1'b0;
      check("full_pop_drained", in_valid, 0);

      // back-to-back results: 32 beats, no bubble
      a = 64'h0123_4567_89AB_CDEF;
      b = 64'hFEDC_BA98_7654_3210;
      res_valid = 1'b1; res_word = a;
      check("ser_idle_ready", res_ready, 1);
      tick();
      res_word = b;
      for (int i = 0; i < 2*NO; i++) begin
         if (i == NO) res_valid = 1'b0;
         exp_nib = (i < NO) ? (a >> (OUT_W*i)) : (b >> (OUT_W*(i-NO)));
         exp_nib = exp_nib & ((64'd1 << OUT_W) - 64'd1);
         check("ser_valid", pad_out_valid, 1);
         check("ser_beat", pad_out, exp_nib);
         if (i == 3) check("ser_busy_not_ready", res_ready, 0);
         if (i == NO-1) check("ser_last_ready", res_ready, 1);
         tick();
      end
      check("ser_back_idle", pad_out_valid, 0);
      check("ser_idle_ready_again", res_ready, 1);

      // reset during a partial input word and mid-SHIFT
      r = {$urandom, $urandom};
      x = {$urandom, $urandom};
      res_valid = 1'b1; res_word = r;
      tick();
      res_valid = 1'b0;
      pad_valid = 1'b1; pad_data = x[IN_W-1:0]; pad_par = ~^pad_data;
      tick();
      pad_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("rst_mid_beat5", pad_out, (r >> (OUT_W*5)) & ((64'd1 << OUT_W) - 64'd1));
      do_reset();
      check_reset_vals("rst_mid");
      x = {$urandom, $urandom};
      send_word(x, 1'b0);
      check("rst_mid_word_valid", in_valid, 1);
      check("rst_mid_word", in_word, x);
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;

      // parity behaviour on a beat with even overall parity
      pad_valid = 1'b1; pad_data = 32'h0000_0001; pad_par = 1'b1;
      tick();
      pad_data = 32'h0000_0000; pad_par = 1'b1;
`ifdef ASCON_BRIDGE_PARITY_EN
      check("par_err_set", err, 1);
      tick();
      pad_valid = 1'b0;
      check("par_word_dropped", in_valid, 0);
      check("par_no_ovf", ovf, 0);
      do_reset();
`else
      check("par_err_tied", err, 0);
      tick();
      pad_valid = 1'b0;
      check("par_word_kept", in_word, 64'h0000_0000_0000_0001);
      check("par_err_still_tied", err, 0);
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
`endif

      // randomized traffic against a queue model; masters honour pad_ready at word start
      sent = 0; bi = 0; cur = '0; cyc = 0;
      while ((sent < 20 || q.size() != 0 || bi != 0) && cyc < 2000) begin
         in_ready = 1'($urandom_range(0, 1));
         if (in_valid && in_ready) begin
            if (q.size() > 0) check("rand_pop_word", in_word, q.pop_front());
            else check("rand_pop_extra", in_valid, 0);
         end
         pad_valid = 1'b0;
         if (bi == 0 && sent < 20 && pad_ready && $urandom_range(0, 3) != 0) begin
            cur = {$urandom, $urandom};
            sent++;
            bi = 1;
            pad_valid = 1'b1;
            pad_data  = cur[IN_W-1:0];
         end else if (bi != 0 && $urandom_range(0, 3) != 0) begin
            pad_valid = 1'b1;
            pad_data  = cur[bi*IN_W +: IN_W];
            bi++;
         end
         pad_par = ~^pad_data;
         if (pad_valid && bi == NB) begin
            q.push_back(cur);
            bi = 0;
         end
         tick();
         cyc++;
      end
      pad_valid = 1'b0;
      in_ready  = 1'b0;
      check("rand_all_sent", sent, 20);
      check("rand_drained", q.size(), 0);
      check("rand_no_ovf", ovf, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
